// File: rtl/serv_rf_ram_sched.sv
// serv_rf_ram_sched
//   Schedules the serial register-file port pair (2 read, 2 write, W bits per
//   step) onto a single simple dual-port RAM (1R1W, RW-bit words, one cycle
//   registered read latency).
//   - Write side: serial data is packed into RAM words and written out one
//     cycle after the step that completes a word. If both ports complete in
//     the same step, port 0 goes first and port 1 follows a cycle later.
//   - Read side: i_rreq fetches word 0 of both registers (rs1 then rs2),
//     pulses o_ready, then streams LSB first. Every port has a shift register
//     and a holding register for the next word. A new word is prefetched as
//     soon as the holding register is loaded into the shift register.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_rreq, o_ready           read start pulse / first words buffered pulse
//   i_cnt_en                  advance one W-bit step (both streams)
//   i_rreg0/1, o_rdata0/1     read port registers and serial read data
//   i_wreg0/1, i_wen0/1,
//   i_wdata0/1                write port registers, enables, serial data
//   o_waddr/o_wdata/o_wen     RAM write port (registered)
//   o_raddr/o_ren, i_rdata    RAM read port; i_rdata valid 1 cycle after o_ren
//
// Configuration
//   SERV_RF_RAM_SCHED_X0_GUARD_EN: when defined, reads of register 0 return
//   zeros without touching the RAM, and writes to register 0 are dropped.
module serv_rf_ram_sched #(
  parameter  int WITH_CSR = 1,
  parameter  int W        = 1,
  parameter  int RW       = 8,
  localparam int RAW      = $clog2((32 + 4 * WITH_CSR) * 32 / RW)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rreq,
  output logic                  o_ready,
  input  logic                  i_cnt_en,
  input  logic [4+WITH_CSR:0]   i_rreg0,
  input  logic [4+WITH_CSR:0]   i_rreg1,
  output logic [W-1:0]          o_rdata0,
  output logic [W-1:0]          o_rdata1,
  input  logic [4+WITH_CSR:0]   i_wreg0,
  input  logic [4+WITH_CSR:0]   i_wreg1,
  input  logic                  i_wen0,
  input  logic                  i_wen1,
  input  logic [W-1:0]          i_wdata0,
  input  logic [W-1:0]          i_wdata1,
  output logic [RAW-1:0]        o_waddr,
  output logic [RW-1:0]         o_wdata,
  output logic                  o_wen,
  output logic [RAW-1:0]        o_raddr,
  output logic                  o_ren,
  input  logic [RW-1:0]         i_rdata
);

  localparam int RB   = 5 + WITH_CSR;     // register address width
  localparam int NW   = 32 / RW;          // RAM words per register
  localparam int SS   = RW / W;           // steps per RAM word
  localparam int NPOS = 32 / W;           // steps per register
  localparam int PB   = $clog2(NPOS);
  localparam int FB   = $clog2(NW + 1);   // fetch index, counts up to NW

`ifdef SERV_RF_RAM_SCHED_X0_GUARD_EN
  localparam bit X0G = 1'b1;
`else
  localparam bit X0G = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FILL1, FILL2, STREAM} state_t;

  // RAM address = register * words-per-register + word index
  function automatic logic [RAW-1:0] addr_of(input logic [RB-1:0] r, input int w);
    int a;
    a = int'(r) * NW + w;
    return a[RAW-1:0];
  endfunction

  // ---------------------------------------------------------------- step count
  logic [PB-1:0] pos;
  logic          sub_last, pos_last;
  int            word;

  assign sub_last = (int'(pos) % SS) == SS - 1;
  assign pos_last = int'(pos) == NPOS - 1;
  assign word     = int'(pos) / SS;

  always_ff @(posedge i_clk) begin
    if (i_rst)         pos <= '0;
    else if (i_cnt_en) pos <= pos_last ? '0 : pos + 1'b1;
  end

  // ---------------------------------------------------------------- read side
  state_t                 state;
  logic [1:0][RB-1:0]     rreg_q;
  logic [1:0]             zr;       // port reads register 0 under the x0 guard
  logic [1:0][RW-1:0]     shift, hold;
  logic [1:0]             hfull, infl;
  logic [1:0][FB-1:0]     fw;       // next word index to fetch per port
  logic                   rv, rp;   // read return pending next cycle, and its port
  logic                   ready;
  logic [1:0]             can, iss;
  logic                   zr_new0, zr_new1;
  logic                   load, shift_en;

  assign zr_new0 = X0G && (i_rreg0 == '0);
  assign zr_new1 = X0G && (i_rreg1 == '0);

  always_comb begin
    can = '0;
    for (int p = 0; p < 2; p++)
      can[p] = (state == STREAM) && !hfull[p] && !infl[p] && (int'(fw[p]) < NW);
  end

  // one prefetch per cycle, rs1 has priority; a new request overrides it
  assign iss[0] = !i_rreq && can[0];
  assign iss[1] = !i_rreq && !can[0] && can[1];

  // holding register moves into the shift register on the step after a word
  // is fully shifted out, except after the last word of the register
  assign shift_en = (state == STREAM) && i_cnt_en;
  assign load     = shift_en && sub_last && !pos_last;

  // read port is driven combinationally so the first fetch goes out in the
  // same cycle as i_rreq
  always_comb begin
    o_ren   = 1'b0;
    o_raddr = '0;
    if (i_rreq) begin
      o_ren   = !zr_new0;
      o_raddr = addr_of(i_rreg0, 0);
    end else if (state == FILL1) begin
      o_ren   = !zr[1];
      o_raddr = addr_of(rreg_q[1], 0);
    end else if (iss[0]) begin
      o_ren   = !zr[0];
      o_raddr = addr_of(rreg_q[0], int'(fw[0]));
    end else if (iss[1]) begin
      o_ren   = !zr[1];
      o_raddr = addr_of(rreg_q[1], int'(fw[1]));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      rreg_q <= '0;
      zr     <= '0;
      shift  <= '0;
      hold   <= '0;
      hfull  <= '0;
      infl   <= '0;
      fw     <= '0;
      rv     <= 1'b0;
      rp     <= 1'b0;
      ready  <= 1'b0;
    end else begin
      ready <= 1'b0;
      rv    <= 1'b0;
      if (i_rreq) begin
        // restart: anything buffered or in flight is dropped
        state     <= FILL1;
        rreg_q[0] <= i_rreg0;
        rreg_q[1] <= i_rreg1;
        zr        <= {zr_new1, zr_new0};
        hfull     <= '0;
        infl      <= '0;
        fw        <= {FB'(1), FB'(1)};
      end else begin
        unique case (state)
          FILL1: begin
            shift[0] <= zr[0] ? '0 : i_rdata;
            ready    <= 1'b1;
            state    <= FILL2;
          end
          FILL2: begin
            shift[1] <= zr[1] ? '0 : i_rdata;
            state    <= STREAM;
          end
          STREAM: begin
            rv <= (iss[0] && !zr[0]) || (iss[1] && !zr[1]);
            rp <= iss[1];
            for (int p = 0; p < 2; p++) begin
              if (load) begin
                shift[p] <= hold[p];
                hfull[p] <= 1'b0;
              end else if (shift_en) begin
                shift[p] <= shift[p] >> W;
              end
              if (rv && (int'(rp) == p)) begin
                hold[p]  <= i_rdata;
                hfull[p] <= 1'b1;
                infl[p]  <= 1'b0;
              end
              if (iss[p]) begin
                fw[p] <= fw[p] + FB'(1);
                if (zr[p]) begin
                  // x0 under guard: fill with zeros, no RAM access
                  hold[p]  <= '0;
                  hfull[p] <= 1'b1;
                end else begin
                  infl[p] <= 1'b1;
                end
              end
            end
            if (i_cnt_en && pos_last) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_ready  = ready;
  assign o_rdata0 = shift[0][W-1:0];
  assign o_rdata1 = shift[1][W-1:0];

  // ---------------------------------------------------------------- write side
  logic [1:0][RW-1:0] wbuf, wnext;
  logic               wdone0, wdone1;
  logic               pend;
  logic [RAW-1:0]     paddr;
  logic [RW-1:0]      pdata;

  // serial data enters at the top so the first step ends up in bit 0
  assign wnext[0] = {i_wdata0, wbuf[0][RW-1:W]};
  assign wnext[1] = {i_wdata1, wbuf[1][RW-1:W]};

  assign wdone0 = i_cnt_en && i_wen0 && sub_last && !(X0G && (i_wreg0 == '0));
  assign wdone1 = i_cnt_en && i_wen1 && sub_last && !(X0G && (i_wreg1 == '0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wbuf    <= '0;
      pend    <= 1'b0;
      paddr   <= '0;
      pdata   <= '0;
      o_wen   <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      if (i_cnt_en && i_wen0) wbuf[0] <= wnext[0];
      if (i_cnt_en && i_wen1) wbuf[1] <= wnext[1];
      o_wen <= 1'b0;
      if (wdone0) begin
        o_wen   <= 1'b1;
        o_waddr <= addr_of(i_wreg0, word);
        o_wdata <= wnext[0];
        if (wdone1) begin
          // port 1 loses the single write port this cycle; park it
          pend  <= 1'b1;
          paddr <= addr_of(i_wreg1, word);
          pdata <= wnext[1];
        end
      end else if (wdone1) begin
        o_wen   <= 1'b1;
        o_waddr <= addr_of(i_wreg1, word);
        o_wdata <= wnext[1];
      end else if (pend) begin
        o_wen   <= 1'b1;
        o_waddr <= paddr;
        o_wdata <= pdata;
        pend    <= 1'b0;
      end
    end
  end

endmodule
